// File: rtl/traffic_gen_if.sv
// traffic_gen_if: per-channel valid/ready bus
// master drives payload and valid, slave returns ready
interface traffic_gen_if #(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 4
);
    logic [NUM_CH*WIDTH-1:0] out_data;
    logic [NUM_CH-1:0]       out_valid;
    logic [NUM_CH-1:0]       out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/traffic_gen.sv
// traffic_gen: multi-channel valid/ready traffic source
// one FSM, payload generator and stats pair per channel
module traffic_gen #(
    parameter int WIDTH    = 8,
    parameter int NUM_CH   = 4,
    parameter int FL       = 0,
    parameter int MODE     = 0,
    parameter int NUM_PKTS = 0,
    parameter int SEED     = 1,
    parameter int COUNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    traffic_gen_if.master             bus,
    output logic [NUM_CH*COUNT_W-1:0] sent_count,
    output logic [NUM_CH*COUNT_W-1:0] stall_count,
    output logic                      done
);
    typedef enum logic [1:0] {IDLE, GAP, SEND, DONE} state_t;

    localparam int GAP_W = (FL > 1) ? $clog2(FL + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(FL);

    logic [NUM_CH-1:0]       isDone;
    logic [NUM_CH-1:0]       validVec;
    logic [NUM_CH*WIDTH-1:0] dataVec;

    for (genvar i = 0; i < NUM_CH; i++) begin : gCh
        localparam logic [31:0] SEED_RAW = 32'(SEED + i);
        localparam logic [31:0] SEED_I =
            (SEED_RAW == 32'd0) ? 32'd1 : SEED_RAW;
        localparam logic [31:0] GEN_INIT =
            (MODE == 0) ? SEED_I : 32'(i);

        state_t             state, stateNext;
        logic [GAP_W-1:0]   gapCnt, gapNext;
        logic [31:0]        genVal, genNext;
        logic [31:0]        pktCnt;
        logic [COUNT_W-1:0] sentCnt, stallCnt;
        logic               valid, xfer, lastPkt;

        assign valid   = (state == SEND);
        assign xfer    = valid && bus.out_ready[i];
        assign lastPkt = (NUM_PKTS != 0) &&
                         ((pktCnt + 32'd1) == 32'(NUM_PKTS));

        if (MODE == 0) begin : gLfsr
            assign genNext = {genVal[30:0],
                genVal[31] ^ genVal[21] ^ genVal[1] ^ genVal[0]};
        end else if (MODE == 1) begin : gInc
            assign genNext = genVal + 32'd1;
        end else begin : gConst
            assign genNext = genVal;
        end

        // next state and gap counter for this channel
        always_comb begin
            stateNext = state;
            gapNext   = gapCnt;
            unique case (state)
                IDLE: begin
                    if (enable) begin
                        if (FL == 0) begin
                            stateNext = SEND;
                        end else begin
                            stateNext = GAP;
                            gapNext   = GAP_LOAD;
                        end
                    end
                end
                GAP: begin
                    if (!enable) begin
                        stateNext = IDLE;
                    end else if (gapCnt <= GAP_W'(1)) begin
                        stateNext = SEND;
                    end else begin
                        gapNext = gapCnt - GAP_W'(1);
                    end
                end
                SEND: begin
                    if (xfer) begin
                        if (lastPkt) begin
                            stateNext = DONE;
                        end else if (!enable) begin
                            stateNext = IDLE;
                        end else if (FL != 0) begin
                            stateNext = GAP;
                            gapNext   = GAP_LOAD;
                        end
                    end
                end
                DONE: stateNext = DONE;
            endcase
        end

        // state, payload generator and saturating statistics
        always_ff @(posedge clk) begin
            if (reset) begin
                state    <= IDLE;
                gapCnt   <= '0;
                genVal   <= GEN_INIT;
                pktCnt   <= '0;
                sentCnt  <= '0;
                stallCnt <= '0;
            end else begin
                state  <= stateNext;
                gapCnt <= gapNext;
                if (xfer) begin
                    genVal <= genNext;
                    pktCnt <= pktCnt + 32'd1;
                    if (sentCnt != '1) begin
                        sentCnt <= sentCnt + COUNT_W'(1);
                    end
                end
                if (valid && !bus.out_ready[i] && stallCnt != '1) begin
                    stallCnt <= stallCnt + COUNT_W'(1);
                end
            end
        end

        assign validVec[i] = valid;
        assign isDone[i]   = (state == DONE);
        assign dataVec[i*WIDTH +: WIDTH] =
            valid ? WIDTH'(genVal) : '0;
        assign sent_count[i*COUNT_W +: COUNT_W]  = sentCnt;
        assign stall_count[i*COUNT_W +: COUNT_W] = stallCnt;
    end

    assign bus.out_valid = validVec;
    assign bus.out_data  = dataVec;

    // done lags the last channel entering DONE by one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            done <= 1'b0;
        end else begin
            done <= &isDone;
        end
    end
endmodule
